arb8_ctl: RTL and testbench
===========================

# arb8_ctl

Sequential 8-requester arbiter that shares a single resource, such as a downstream bus or a priority-encoded datapath, among eight clients. It samples a request vector, selects one winner by descending-index priority (or round-robin when configured), and holds a registered one-hot grant while the winner keeps requesting. It forcibly revokes grants that exceed a hold limit. It sits between client request lines and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive grant cycles per ownership, legal range 0..255; 0 disables the timeout.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request lines, bit i = client i; level-sensitive.
- `gnt` output 8: registered one-hot grant, at most one bit set.
- `gnt_id` output 3: binary index of granted client; 0 when `gnt_v`=0.
- `gnt_v` output 1: high while any grant is held (equals OR of `gnt`).

## Operation
- Eligible vector: `elig` = `req` & ~`mask`.
- Winner under fixed priority: highest set index of `elig` (bit 7 beats bit 0).
- States:
  - IDLE: no grant. If `elig`≠0, go to GRANT with the winner loaded; otherwise stay.
  - GRANT: hold `gnt`/`gnt_id`; hold counter `hcnt` increments each cycle.
    - If `req[gnt_id]`=0 at an edge: go to GAP.
    - Else if `MAX_HOLD`≠0 and `hcnt`==`MAX_HOLD`: go to GAP, and set `mask[gnt_id]`.
  - GAP: exactly one cycle with no grant (turnaround). Then go to GRANT with a new winner if `elig`≠0, else to IDLE.
- Hold counter: 8 bits. Loaded to 1 on entry to GRANT, increments in GRANT, cleared in IDLE/GAP. It never wraps because `MAX_HOLD` ≤ 255.
- Mask register, 8 bits:
  - Bit i is set on timeout of client i.
  - Bit i is cleared at any edge where `req[i]`=0. Clear has no priority conflict because set requires `req[i]`=1.
  - Masked clients are never granted until they deassert for at least one cycle.
- If all requesting clients are masked, the arbiter stays IDLE.
- Requests from non-granted clients never preempt an active grant.

## Timing
- Reset values: `gnt`=8'h00, `gnt_id`=3'd0, `gnt_v`=0, state=IDLE, `hcnt`=0, `mask`=8'h00, `last`=3'd0.
- Reset is asynchronous: outputs clear immediately on `rst` rise, including mid-grant.
- Grant latency: `req` seen at edge N from IDLE gives `gnt` valid after edge N.
- Release: `req[gnt_id]` low at edge N drops `gnt` after edge N. The next grant is no earlier than after edge N+1 (one GAP cycle).
- Timeout: `gnt` is high for exactly `MAX_HOLD` cycles when the owner never releases. It drops after the edge where `hcnt`==`MAX_HOLD`.
- A request pulse shorter than one cycle between edges is not seen.
- A request that drops in the same cycle it would be granted is not granted (sampling uses the current `req`).
- `gnt`, `gnt_id` and `gnt_v` all change on the same edge; no combinational path from `req` to outputs.

## Configuration
- Macro: `ARB8_RR_EN`.
- Defined (round-robin):
  - Register `last` stores the index of each granted client.
  - Search order is `last`-1, `last`-2, … wrapping mod 8, ending at `last`; the first set `elig` bit wins.
  - Because `last` resets to 0, the first arbitration after reset uses order 7..0, identical to fixed priority.
- Undefined (fixed priority):
  - `last` is not implemented.
  - Priority is always 7 > 6 > … > 0.

## Test plan
- Reset then `req`=8'h05 held: after 1 edge `gnt`=8'h04, `gnt_id`=2, `gnt_v`=1. Drop `req[2]`: 1 edge later `gnt`=0, then next edge `gnt`=8'h01.
- `req`=8'h81 simultaneous from IDLE: `gnt`=8'h80. With `ARB8_RR_EN`, after client 7 releases and re-requests alongside client 0, the next grant is client 0; without the macro, it is client 7.
- `MAX_HOLD`=4, `req`=8'h10 held forever:
  - `gnt`=8'h10 for exactly 4 cycles, then 0.
  - No re-grant while `req[4]` stays high (masked).
  - Drop `req[4]` 1 cycle and reassert: granted again.
- `MAX_HOLD`=4, `req`=8'h30 held: client 5 times out, GAP, then client 4 granted for 4 cycles. Afterwards both are masked, the arbiter stays IDLE, and `gnt_v`=0.
- Assert `rst` mid-grant (`gnt`=8'h08): outputs 0 immediately, without waiting for a clock edge. After release with `req`=8'h08 still high: grant returns 1 edge later with `hcnt` restarting and `mask`=0.
- `MAX_HOLD`=0, `req`=8'h02 held 300 cycles: `gnt`=8'h02 continuously, with no timeout and no counter wrap effect.

Source files
------------

// File: rtl/arb8_ctl.sv
// -----------------------------------------------------------------------------
// arb8_ctl
//
// Purpose:
//    Eight-client arbiter for one shared resource. Each cycle it forms the
//    eligible set (requests not blocked by the timeout mask) and picks one
//    winner. The winner holds a registered one-hot grant while it keeps
//    requesting. A grant is revoked when the hold counter reaches MAX_HOLD.
//    Every release or revoke is followed by exactly one idle turnaround cycle.
//
// Configuration:
//    ARB8_RR_EN  - when defined, round-robin arbitration. The search starts
//                  just below the last granted index and wraps.
//                  When undefined, fixed priority applies: 7 > 6 > ... > 0.
//
// Parameters:
//    MAX_HOLD    - maximum consecutive grant cycles (0..255, 0 = no timeout)
//
// Ports:
//    clk         - clock, rising edge
//    rst         - asynchronous active-high reset
//    req[7:0]    - level-sensitive request lines, bit i = client i
//    gnt[7:0]    - registered one-hot grant
//    gnt_id[2:0] - index of granted client, 0 when no grant
//    gnt_v       - high while a grant is held
// -----------------------------------------------------------------------------
module arb8_ctl #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_v
);

   localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_GAP
   } state_t;

   state_t     r_state;
   logic [7:0] r_gnt;
   logic [2:0] r_gnt_id;
   logic       r_gnt_v;
   logic [7:0] r_hcnt;
   logic [7:0] r_mask;
`ifdef ARB8_RR_EN
   logic [2:0] r_last;
`endif

   logic [7:0] w_elig;
   logic       w_win_found;
   logic [2:0] w_win_id;
   logic [2:0] w_idx;
   logic       w_owner_req;
   logic       w_timeout;

   assign w_elig      = req & ~r_mask;
   assign w_owner_req = req[r_gnt_id];
   assign w_timeout   = (LP_MAX_HOLD != '0) && (r_hcnt == LP_MAX_HOLD);

   // Winner selection. The scan runs upward from the reference index. A later
   // hit overwrites an earlier one, so the index just below the reference has
   // the highest priority. The reference is r_last for round-robin and 0 for
   // fixed priority. With reference 0 the scan gives plain 7 > ... > 0.
   always_comb begin
      w_win_found = |w_elig;
      w_win_id    = '0;
      w_idx       = '0;
      for (int unsigned k = 0; k < 8; k++) begin
`ifdef ARB8_RR_EN
         w_idx = r_last + 3'(k);
`else
         w_idx = 3'(k);
`endif
         if (w_elig[w_idx]) begin
            w_win_id = w_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_gnt_v  <= 1'b0;
         r_hcnt   <= '0;
         r_mask   <= '0;
`ifdef ARB8_RR_EN
         r_last   <= '0;
`endif
      end else begin
         // A mask bit stays set only while its client keeps requesting.
         // A timeout sets its bit below. The timeout needs req high, so the
         // set and the clear never act on the same bit.
         r_mask <= r_mask & req;

         case (r_state)
            ST_IDLE, ST_GAP: begin
               if (w_win_found) begin
                  r_state  <= ST_GRANT;
                  r_gnt    <= 8'(1) << w_win_id;
                  r_gnt_id <= w_win_id;
                  r_gnt_v  <= 1'b1;
                  r_hcnt   <= 8'd1;
`ifdef ARB8_RR_EN
                  r_last   <= w_win_id;
`endif
               end else begin
                  r_state  <= ST_IDLE;
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_gnt_v  <= 1'b0;
                  r_hcnt   <= '0;
               end
            end

            ST_GRANT: begin
               if (!w_owner_req) begin
                  r_state  <= ST_GAP;
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_gnt_v  <= 1'b0;
                  r_hcnt   <= '0;
               end else if (w_timeout) begin
                  r_state  <= ST_GAP;
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_gnt_v  <= 1'b0;
                  r_hcnt   <= '0;
                  r_mask   <= (r_mask & req) | (8'(1) << r_gnt_id);
               end else begin
                  // Saturating count. Only MAX_HOLD = 0 holds long enough to
                  // reach 255, and that setting ignores the count.
                  if (r_hcnt != 8'hFF) begin
                     r_hcnt <= r_hcnt + 8'd1;
                  end
               end
            end

            default: begin
               r_state  <= ST_IDLE;
               r_gnt    <= '0;
               r_gnt_id <= '0;
               r_gnt_v  <= 1'b0;
               r_hcnt   <= '0;
            end
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign gnt_id = r_gnt_id;
   assign gnt_v  = r_gnt_v;

endmodule

// File: tb/tb_arb8_ctl.sv
// -----------------------------------------------------------------------------
// tb_arb8_ctl
//
// Self-checking bench for arb8_ctl with three instances:
//    u_d4  - MAX_HOLD = 4
//    u_d0  - MAX_HOLD = 0 (timeout disabled)
//    u_d15 - default MAX_HOLD (15)
// The stimulus pushes the hand-computed grant expected after each edge. The
// monitor pops one entry per cycle and compares gnt, gnt_id and gnt_v.
// -----------------------------------------------------------------------------
module tb_arb8_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req4, req0, req15;
   logic [7:0] g4, g0, g15;
   logic [2:0] id4, id0, id15;
   logic       v4, v0, v15;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cur_test = 0;
   int unsigned step_no  = 0;

   int unsigned q_which[$];
   logic [7:0]  q_gnt[$];
   int unsigned q_tag[$];

   always #5 clk = ~clk;

   arb8_ctl #(.MAX_HOLD(4)) u_d4 (
      .clk(clk), .rst(rst), .req(req4), .gnt(g4), .gnt_id(id4), .gnt_v(v4)
   );

   arb8_ctl #(.MAX_HOLD(0)) u_d0 (
      .clk(clk), .rst(rst), .req(req0), .gnt(g0), .gnt_id(id0), .gnt_v(v0)
   );

   arb8_ctl u_d15 (
      .clk(clk), .rst(rst), .req(req15), .gnt(g15), .gnt_id(id15), .gnt_v(v15)
   );

   // Queue the grant that must be visible at the next monitor sample.
   task automatic expect_gnt(input int unsigned which, input logic [7:0] e);
      q_which.push_back(which);
      q_gnt.push_back(e);
      q_tag.push_back(cur_test * 1000 + step_no);
      step_no++;
   endtask

   // Drive one request vector for one clock edge and queue the expected grant.
   task automatic step(input int unsigned which, input logic [7:0] r,
                       input logic [7:0] e);
      case (which)
         0:       req4  = r;
         1:       req0  = r;
         default: req15 = r;
      endcase
      expect_gnt(which, e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic hold(input int unsigned which, input logic [7:0] r,
                       input logic [7:0] e, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         step(which, r, e);
      end
   endtask

   // Monitor / scoreboard
   initial begin : monitor
      int unsigned w, t;
      logic [7:0]  e, a_g;
      logic [2:0]  e_id, a_id;
      logic        e_v, a_v;
      forever begin
         @(negedge clk);
         if (q_gnt.size() != 0) begin
            w = q_which.pop_front();
            e = q_gnt.pop_front();
            t = q_tag.pop_front();
            case (w)
               0:       begin a_g = g4;  a_id = id4;  a_v = v4;  end
               1:       begin a_g = g0;  a_id = id0;  a_v = v0;  end
               default: begin a_g = g15; a_id = id15; a_v = v15; end
            endcase
            e_id = '0;
            for (int i = 0; i < 8; i++) begin
               if (e[i]) e_id = 3'(i);
            end
            e_v = |e;
            n_checks++;
            if (a_g !== e || a_id !== e_id || a_v !== e_v) begin
               n_errors++;
               $display("FAIL gnt dut%0d test%0d.step%0d: got gnt=%h id=%0d v=%b, expected gnt=%h id=%0d v=%b",
                        w, t / 1000, t % 1000, a_g, a_id, a_v, e, e_id, e_v);
            end
         end
      end
   end

   initial begin : stimulus
      rst   = 1'b1;
      req4  = '0;
      req0  = '0;
      req15 = '0;

      // 1: reset state on every instance
      cur_test = 1; step_no = 0;
      step(0, 8'h00, 8'h00);
      step(1, 8'h00, 8'h00);
      step(2, 8'h00, 8'h00);
      rst = 1'b0;

      // 2: simultaneous 7 and 0; after 7 releases and re-requests with 0
      cur_test = 2; step_no = 0;
      step(0, 8'h81, 8'h80);
      step(0, 8'h01, 8'h00);
`ifdef ARB8_RR_EN
      step(0, 8'h81, 8'h01);
`else
      step(0, 8'h81, 8'h80);
`endif
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 3: sub-cycle request pulse is not granted
      cur_test = 3; step_no = 0;
      req4 = 8'h80;
      #2;
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 4: priority, release with one GAP cycle, no preemption
      cur_test = 4; step_no = 0;
      step(0, 8'h05, 8'h04);
      step(0, 8'h05, 8'h04);
      step(0, 8'h01, 8'h00);
      step(0, 8'h01, 8'h01);
      step(0, 8'h81, 8'h01);
      step(0, 8'h81, 8'h01);
      step(0, 8'h80, 8'h00);
      step(0, 8'h80, 8'h80);
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 5: timeout after exactly 4 cycles, masked, re-grant after a drop
      cur_test = 5; step_no = 0;
      hold(0, 8'h10, 8'h10, 4);
      step(0, 8'h10, 8'h00);
      hold(0, 8'h10, 8'h00, 3);
      step(0, 8'h00, 8'h00);
      step(0, 8'h10, 8'h10);
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 6: two clients time out in turn, then both masked and idle
      cur_test = 6; step_no = 0;
      hold(0, 8'h30, 8'h20, 4);
      step(0, 8'h30, 8'h00);
      hold(0, 8'h30, 8'h10, 4);
      step(0, 8'h30, 8'h00);
      hold(0, 8'h30, 8'h00, 3);
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 7: asynchronous reset mid-grant, then a fresh 4-cycle hold
      cur_test = 7; step_no = 0;
      step(0, 8'h08, 8'h08);
      step(0, 8'h08, 8'h08);
      @(posedge clk);
      #2;
      rst = 1'b1;
      expect_gnt(0, 8'h00);
      @(negedge clk);
      #1;
      step(0, 8'h08, 8'h00);
      rst = 1'b0;
      hold(0, 8'h08, 8'h08, 4);
      step(0, 8'h08, 8'h00);
      step(0, 8'h00, 8'h00);
      step(0, 8'h00, 8'h00);

      // 8: MAX_HOLD = 0 never times out
      cur_test = 8; step_no = 0;
      hold(1, 8'h02, 8'h02, 301);
      step(1, 8'h00, 8'h00);
      step(1, 8'h00, 8'h00);

      // 9: default MAX_HOLD = 15
      cur_test = 9; step_no = 0;
      hold(2, 8'h01, 8'h01, 15);
      step(2, 8'h01, 8'h00);
      step(2, 8'h01, 8'h00);
      step(2, 8'h00, 8'h00);
      step(2, 8'h01, 8'h01);
      step(2, 8'h00, 8'h00);

      // Give the monitor a bounded number of cycles to consume what is left.
      for (int unsigned i = 0; i < 5 && q_gnt.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (q_gnt.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q_gnt.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
